reg_sipo_window_rf: RTL and testbench
=====================================

// Module: reg_sipo_window_rf
// PURPOSE
//  Parametrised register file: serial write in, parallel read out. Each read returns a window of
//  NTAP consecutive entries. It sits between the byte-serial input stream and the windowed
//  datapath (filter/conv taps). Over the 32x8 3-tap generation it adds: generic width, depth and
//  tap count; an auto-increment write pointer; wrap or clamp addressing; same-cycle read+write
//  with write-first bypass; per-entry valid bits; synchronous clear.
// PARAMETERS
//  DW     8                data width per entry
//  DEPTH  32               number of entries, >= NTAP
//  AW     $clog2(DEPTH)    address width (derived; do not override)
//  NTAP   3                window size, i.e. entries returned per read
//  WRAP   1                1: tap address = (rd_addr+k) mod DEPTH; 0: taps past DEPTH-1 are invalid
// PORTS
//  clk         in   1        rising-edge clock, single clock domain
//  rst         in   1        asynchronous reset, active-high
//  en          in   1        global enable; 0 freezes array, pointer and outputs (rd_valid -> 0)
//  clr         in   1        synchronous clear of data, valid bits and write pointer
//  wr_en       in   1        write strobe
//  wr_auto     in   1        1: write at wr_ptr; 0: write at wr_addr
//  wr_addr     in   AW       explicit write address
//  din         in   DW       write data
//  rd_req      in   1        read request, single-cycle pulse or held
//  rd_addr     in   AW       window base address
//  rd_valid    out  1        one-cycle pulse: rd_data is fresh
//  rd_data     out  NTAP*DW  tap k occupies bits [k*DW +: DW]; tap 0 is at rd_addr
//  rd_tap_vld  out  NTAP     tap k is in range and its entry has been written since clear/reset
//  wr_ptr      out  AW       next auto-write address
// BEHAVIOUR
//  - Reset (async): all entries, valid bits, rd_data, rd_tap_vld, rd_valid and wr_ptr go to 0.
//    The next edge after rst deasserts is a normal cycle.
//  - Every action below requires en=1. With en=0, state holds and rd_valid=0 on the next edge.
//  - Write: wr_en=1 -> entry[A] <= din and vld[A] <= 1, with A = wr_auto ? wr_ptr : wr_addr.
//  - wr_ptr advances by 1 only on an auto write, and wraps DEPTH-1 -> 0 in every WRAP mode.
//  - Read: rd_req=1 at edge N -> rd_data and rd_tap_vld are registered at edge N.
//    rd_valid=1 for the cycle after edge N. Latency is 1.
//  - Outputs hold their value until the next accepted read. Back-to-back reads give one result
//    per cycle.
//  - Tap address is t_k = rd_addr + k.
//  - WRAP=1: t_k is taken modulo DEPTH (AW+1-bit add, then compare and subtract if
//    DEPTH is not a power of 2).
//  - WRAP=0: if t_k >= DEPTH, tap k data = 0 and rd_tap_vld[k] = 0.
//  - Simultaneous read and write are legal. Write-first bypass: if a write targets t_k in the same
//    cycle, tap k returns din and rd_tap_vld[k] = 1.
//  - clr=1 (en=1): every entry and valid bit -> 0 and wr_ptr -> 0. A write in the same cycle is
//    dropped (clr wins).
//  - A read in the same cycle as clr returns pre-clear contents, with no bypass.
//  - Out-of-range wr_addr (>= DEPTH, possible when DEPTH is not a power of 2): the write is ignored.
//  - Out-of-range rd_addr: treated modulo DEPTH if WRAP=1; all taps invalid if WRAP=0.
//  - There are no illegal input combinations, so no assertion fires on read+write.
// STRUCTURE
//  - Package reg_sipo_pkg:
//      function tap_addr(base, k, depth, wrap) returning {in_range, addr};
//      localparam defaults DW_DEF=8, DEPTH_DEF=32, NTAP_DEF=3.
//  - Sub-module reg_sipo_tap_sel, combinational, one instance per tap via generate:
//    computes t_k and the range check, muxes entry / din-bypass, and outputs tap data and valid.
//  - Top level holds the array, the valid-bit vector, wr_ptr, and the output registers.
// TESTING
//  1. Reset: rst pulse mid-stream -> rd_data, rd_tap_vld, rd_valid and wr_ptr read 0
//     immediately (async, not edge-aligned).
//  2. Auto write: write 0x10..0x2F with wr_auto=1 -> wr_ptr wraps to 0.
//     Then rd_addr=5 -> {0x17,0x16,0x15}, tap_vld=3'b111, rd_valid pulses once.
//  3. Wrap/clamp, after writing 0x10..0x2F:
//     WRAP=1, rd_addr=31 -> {0x11,0x10,0x2F}, vld=111.
//     WRAP=0, rd_addr=30 -> {0x00,0x2F,0x2E}, vld=3'b011.
//  4. Bypass: wr_en at addr 6 with din=0xAA in the same cycle as rd_req with rd_addr=5
//     -> tap1=0xAA. The entry reads 0xAA afterwards.
//  5. Clear: clr with wr_en and rd_req in the same cycle -> the read returns old data and the
//     write is dropped. The next read gives vld=000, data=0, and wr_ptr=0.
//  6. Enable gate: en=0 with wr_en and rd_req held for 4 cycles -> no state change, rd_valid=0.
//     Then en=1 -> normal operation resumes.

Source files
------------

// File: rtl/reg_sipo_window_rf_pkg.sv
// ---------------------------------------------------------------------------
// reg_sipo_pkg
//   Shared defaults and the tap address helper for the serial-in,
//   window-out register file.
//   tap_addr(base, k, depth, wrap) returns {in_range, addr[31:0]}.
// ---------------------------------------------------------------------------
package reg_sipo_pkg;

  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 32;
  localparam int NTAP_DEF  = 3;

  // Tap k sits at base+k.
  // Wrap mode: base is at most 2^AW-1, which is below 2*depth, and k is
  // below depth. The sum is therefore below 3*depth, so two conditional
  // subtractions always bring it into range.
  // Clamp mode: any sum at or past depth is reported as out of range. An
  // out-of-range base is included, because it always gives such a sum.
  function automatic logic [32:0] tap_addr(input logic [31:0] base,
                                           input logic [31:0] k,
                                           input logic [31:0] depth,
                                           input logic        wrap);
    logic [31:0] sum;
    logic        in_range;
    sum = base + k;
    if (wrap) begin
      if (sum >= depth) sum = sum - depth;
      else              sum = sum;
      if (sum >= depth) sum = sum - depth;
      else              sum = sum;
      in_range = 1'b1;
    end else begin
      in_range = (sum < depth);
    end
    return {in_range, sum};
  endfunction

endpackage

// File: rtl/reg_sipo_window_rf_if.sv
// ---------------------------------------------------------------------------
// reg_sipo_window_rf_if
//   Bus bundle for the window register file.
//   master: drives en/clr, the write port (wr_en, wr_auto, wr_addr, din) and
//           the read request (rd_req, rd_addr).
//   slave : returns rd_valid, rd_data (NTAP*DW), rd_tap_vld (NTAP), wr_ptr.
// ---------------------------------------------------------------------------
interface reg_sipo_window_rf_if
  import reg_sipo_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int NTAP  = NTAP_DEF
);
  localparam int AW = $clog2(DEPTH);

  logic                 en;
  logic                 clr;
  logic                 wr_en;
  logic                 wr_auto;
  logic [AW-1:0]        wr_addr;
  logic [DW-1:0]        din;
  logic                 rd_req;
  logic [AW-1:0]        rd_addr;
  logic                 rd_valid;
  logic [NTAP*DW-1:0]   rd_data;
  logic [NTAP-1:0]      rd_tap_vld;
  logic [AW-1:0]        wr_ptr;

  modport master (
    output en, clr, wr_en, wr_auto, wr_addr, din, rd_req, rd_addr,
    input  rd_valid, rd_data, rd_tap_vld, wr_ptr
  );

  modport slave (
    input  en, clr, wr_en, wr_auto, wr_addr, din, rd_req, rd_addr,
    output rd_valid, rd_data, rd_tap_vld, wr_ptr
  );

endinterface

// File: rtl/reg_sipo_window_rf_tap_sel.sv
// ---------------------------------------------------------------------------
// reg_sipo_tap_sel
//   Combinational selector for one window tap (index K).
//   rd_addr_i  : window base address
//   entries_i  : flattened array, entry e at [e*DW +: DW]
//   vld_i      : per-entry written flags
//   byp_en_i   : a write is committed this cycle (already range/clr checked)
//   byp_addr_i : target address of that write
//   din_i      : write data, forwarded on an address match
//   tap_data_o : tap data; zero when out of range
//   tap_vld_o  : tap in range and entry written (or bypassed)
// ---------------------------------------------------------------------------
module reg_sipo_tap_sel
  import reg_sipo_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH),
  parameter int WRAP  = 1,
  parameter int K     = 0
) (
  input  logic [AW-1:0]       rd_addr_i,
  input  logic [DEPTH*DW-1:0] entries_i,
  input  logic [DEPTH-1:0]    vld_i,
  input  logic                byp_en_i,
  input  logic [AW-1:0]       byp_addr_i,
  input  logic [DW-1:0]       din_i,
  output logic [DW-1:0]       tap_data_o,
  output logic                tap_vld_o
);

  logic [32:0]   res_s;
  logic          in_range_s;
  logic [AW-1:0] addr_s;

  // Resolve the tap address, then pick zero, the bypassed write or the stored entry.
  always_comb begin
    res_s      = tap_addr(32'(rd_addr_i), 32'(K), 32'(DEPTH), (WRAP != 0));
    in_range_s = res_s[32];
    addr_s     = AW'(res_s[31:0]);
    tap_data_o = {DW{1'b0}};
    tap_vld_o  = 1'b0;
    if (!in_range_s) begin
      tap_data_o = {DW{1'b0}};
      tap_vld_o  = 1'b0;
    end else if (byp_en_i && (byp_addr_i == addr_s)) begin
      tap_data_o = din_i;
      tap_vld_o  = 1'b1;
    end else begin
      tap_data_o = entries_i[addr_s*DW +: DW];
      tap_vld_o  = vld_i[addr_s];
    end
  end

endmodule

// File: rtl/reg_sipo_window_rf.sv
// ---------------------------------------------------------------------------
// reg_sipo_window_rf
//   Register file with serial writes and windowed parallel reads.
//   clk : rising-edge clock
//   rst : asynchronous reset, active-high
//   bus : slave side of reg_sipo_window_rf_if
//         inputs : en, clr, wr_en, wr_auto, wr_addr, din, rd_req, rd_addr
//         outputs: rd_valid, rd_data, rd_tap_vld, wr_ptr (all registered)
//   Reads have a latency of 1. A write to a tap address in the same cycle
//   is forwarded into that tap. clr wipes the data, the valid bits and the
//   pointer, and suppresses any same-cycle write.
// ---------------------------------------------------------------------------
module reg_sipo_window_rf
  import reg_sipo_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int NTAP  = NTAP_DEF,
  parameter int WRAP  = 1
) (
  input logic                 clk,
  input logic                 rst,
  reg_sipo_window_rf_if.slave bus
);
  localparam int              AW      = $clog2(DEPTH);
  localparam logic [AW:0]     DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]   LAST_A  = AW'(DEPTH-1);

  logic [DEPTH*DW-1:0] mem_q,        mem_d;
  logic [DEPTH-1:0]    vld_q,        vld_d;
  logic [AW-1:0]       wr_ptr_q,     wr_ptr_d;
  logic [NTAP*DW-1:0]  rd_data_q,    rd_data_d;
  logic [NTAP-1:0]     rd_tap_vld_q, rd_tap_vld_d;
  logic                rd_valid_q,   rd_valid_d;

  logic [AW-1:0]       wr_a_s;
  logic                wr_ok_s;
  logic [NTAP*DW-1:0]  tap_data_s;
  logic [NTAP-1:0]     tap_vld_s;

  // Effective write address and write qualification (clr and range drop it).
  always_comb begin
    wr_a_s  = bus.wr_auto ? wr_ptr_q : bus.wr_addr;
    wr_ok_s = bus.en & bus.wr_en & ~bus.clr & ({1'b0, wr_a_s} < DEPTH_W);
  end

  for (genvar k = 0; k < NTAP; k++) begin : g_tap
    reg_sipo_tap_sel #(
      .DW(DW), .DEPTH(DEPTH), .AW(AW), .WRAP(WRAP), .K(k)
    ) u_tap (
      .rd_addr_i  (bus.rd_addr),
      .entries_i  (mem_q),
      .vld_i      (vld_q),
      .byp_en_i   (wr_ok_s),
      .byp_addr_i (wr_a_s),
      .din_i      (bus.din),
      .tap_data_o (tap_data_s[k*DW +: DW]),
      .tap_vld_o  (tap_vld_s[k])
    );
  end

  // Next state of the array, valid bits, write pointer and read outputs.
  always_comb begin
    mem_d        = mem_q;
    vld_d        = vld_q;
    wr_ptr_d     = wr_ptr_q;
    rd_data_d    = rd_data_q;
    rd_tap_vld_d = rd_tap_vld_q;
    rd_valid_d   = 1'b0;
    if (bus.en) begin
      // The taps see the pre-clear array, so a read alongside clr returns old data.
      if (bus.rd_req) begin
        rd_data_d    = tap_data_s;
        rd_tap_vld_d = tap_vld_s;
        rd_valid_d   = 1'b1;
      end else begin
        rd_valid_d   = 1'b0;
      end
      if (bus.clr) begin
        mem_d    = {(DEPTH*DW){1'b0}};
        vld_d    = {DEPTH{1'b0}};
        wr_ptr_d = {AW{1'b0}};
      end else begin
        if (wr_ok_s) begin
          mem_d[wr_a_s*DW +: DW] = bus.din;
          vld_d[wr_a_s]          = 1'b1;
        end else begin
          mem_d = mem_q;
        end
        if (wr_ok_s && bus.wr_auto) begin
          wr_ptr_d = (wr_ptr_q == LAST_A) ? {AW{1'b0}} : (wr_ptr_q + AW'(1));
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
      end
    end else begin
      rd_valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q        <= {(DEPTH*DW){1'b0}};
      vld_q        <= {DEPTH{1'b0}};
      wr_ptr_q     <= {AW{1'b0}};
      rd_data_q    <= {(NTAP*DW){1'b0}};
      rd_tap_vld_q <= {NTAP{1'b0}};
      rd_valid_q   <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      vld_q        <= vld_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_data_q    <= rd_data_d;
      rd_tap_vld_q <= rd_tap_vld_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_tap_vld = rd_tap_vld_q;
  assign bus.wr_ptr     = wr_ptr_q;

endmodule

// File: tb/tb_reg_sipo_window_rf.sv
// ---------------------------------------------------------------------------
// tb_reg_sipo_window_rf
//   Two instances of the register file: one in wrap mode, one in clamp
//   mode. Both receive the same stimulus. Each read pushes the expected
//   window for each instance into that instance's queue. A monitor pops an
//   entry and compares it whenever that instance raises rd_valid.
// ---------------------------------------------------------------------------
module tb_reg_sipo_window_rf;

  typedef struct {
    string      name;
    logic [23:0] data;
    logic [2:0]  vld;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t q_w[$];
  exp_t q_c[$];

  reg_sipo_window_rf_if #(.DW(8), .DEPTH(32), .NTAP(3)) if_w ();
  reg_sipo_window_rf_if #(.DW(8), .DEPTH(32), .NTAP(3)) if_c ();

  assign if_c.en      = if_w.en;
  assign if_c.clr     = if_w.clr;
  assign if_c.wr_en   = if_w.wr_en;
  assign if_c.wr_auto = if_w.wr_auto;
  assign if_c.wr_addr = if_w.wr_addr;
  assign if_c.din     = if_w.din;
  assign if_c.rd_req  = if_w.rd_req;
  assign if_c.rd_addr = if_w.rd_addr;

  reg_sipo_window_rf #(.DW(8), .DEPTH(32), .NTAP(3), .WRAP(1)) u_wrap (
    .clk(clk), .rst(rst), .bus(if_w)
  );
  reg_sipo_window_rf #(.DW(8), .DEPTH(32), .NTAP(3), .WRAP(0)) u_clamp (
    .clk(clk), .rst(rst), .bus(if_c)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Scoreboard monitor: one pop per rd_valid pulse, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (if_w.rd_valid === 1'b1) begin
      if (q_w.size() == 0) begin
        check("wrap_unexpected_valid", 32'(1), 32'(0));
      end else begin
        e = q_w.pop_front();
        check({"wrap_data_", e.name}, 32'(if_w.rd_data), 32'(e.data));
        check({"wrap_vld_", e.name}, 32'(if_w.rd_tap_vld), 32'(e.vld));
      end
    end
    if (if_c.rd_valid === 1'b1) begin
      if (q_c.size() == 0) begin
        check("clamp_unexpected_valid", 32'(1), 32'(0));
      end else begin
        e = q_c.pop_front();
        check({"clamp_data_", e.name}, 32'(if_c.rd_data), 32'(e.data));
        check({"clamp_vld_", e.name}, 32'(if_c.rd_tap_vld), 32'(e.vld));
      end
    end
  end

  task automatic wr_auto_t(input logic [7:0] d);
    if_w.wr_en = 1'b1; if_w.wr_auto = 1'b1; if_w.din = d;
    @(negedge clk);
    if_w.wr_en = 1'b0;
  endtask

  // One-cycle read; the caller may set write/clr strobes beforehand.
  task automatic rd(input string nm, input logic [4:0] a,
                    input logic [23:0] dw, input logic [2:0] vw,
                    input logic [23:0] dc, input logic [2:0] vc);
    if_w.rd_req = 1'b1; if_w.rd_addr = a;
    q_w.push_back('{nm, dw, vw});
    q_c.push_back('{nm, dc, vc});
    @(negedge clk);
    if_w.rd_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    if_w.en = 1'b1; if_w.clr = 1'b0; if_w.wr_en = 1'b0; if_w.wr_auto = 1'b0;
    if_w.wr_addr = 5'd0; if_w.din = 8'h00; if_w.rd_req = 1'b0; if_w.rd_addr = 5'd0;
    repeat (2) @(negedge clk);
    check("rst_rd_valid", 32'(if_w.rd_valid), 32'(0));
    check("rst_rd_data", 32'(if_w.rd_data), 32'(0));
    check("rst_tap_vld", 32'(if_w.rd_tap_vld), 32'(0));
    check("rst_wr_ptr", 32'(if_w.wr_ptr), 32'(0));
    rst = 1'b0;

    // Fill 0x10..0x2F through the auto pointer.
    for (int i = 0; i < 32; i++) begin
      wr_auto_t(8'(8'h10 + i));
      if (i == 4) check("ptr_after5", 32'(if_w.wr_ptr), 32'(5));
    end
    check("ptr_wrapped", 32'(if_w.wr_ptr), 32'(0));
    check("ptr_wrapped_clamp", 32'(if_c.wr_ptr), 32'(0));

    rd("base5", 5'd5, 24'h171615, 3'b111, 24'h171615, 3'b111);
    rd("base31", 5'd31, 24'h11102F, 3'b111, 24'h00002F, 3'b001);
    rd("base30", 5'd30, 24'h102F2E, 3'b111, 24'h002F2E, 3'b011);

    // Write-first bypass into tap 1.
    if_w.wr_en = 1'b1; if_w.wr_auto = 1'b0; if_w.wr_addr = 5'd6; if_w.din = 8'hAA;
    rd("bypass", 5'd5, 24'h17AA15, 3'b111, 24'h17AA15, 3'b111);
    if_w.wr_en = 1'b0;
    rd("after_bypass", 5'd5, 24'h17AA15, 3'b111, 24'h17AA15, 3'b111);

    // Move the pointer off 0 so the clear is visible on it.
    wr_auto_t(8'h33);
    check("ptr_before_clr", 32'(if_w.wr_ptr), 32'(1));

    // clr with write and read: old data comes back, the write is dropped.
    if_w.clr = 1'b1; if_w.wr_en = 1'b1; if_w.wr_auto = 1'b1; if_w.din = 8'h55;
    rd("clr_old", 5'd5, 24'h17AA15, 3'b111, 24'h17AA15, 3'b111);
    if_w.clr = 1'b0; if_w.wr_en = 1'b0;
    check("ptr_after_clr", 32'(if_w.wr_ptr), 32'(0));
    rd("cleared", 5'd0, 24'h000000, 3'b000, 24'h000000, 3'b000);

    // Enable gate: strobes held for 4 cycles with en low.
    if_w.en = 1'b0; if_w.wr_en = 1'b1; if_w.wr_auto = 1'b1; if_w.din = 8'h99;
    if_w.rd_req = 1'b1; if_w.rd_addr = 5'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("gated_rd_valid", 32'(if_w.rd_valid), 32'(0));
    end
    if_w.rd_req = 1'b0;
    check("gated_ptr", 32'(if_w.wr_ptr), 32'(0));
    if_w.en = 1'b1; if_w.wr_en = 1'b0;
    wr_auto_t(8'h99);
    check("resume_ptr", 32'(if_w.wr_ptr), 32'(1));
    rd("resume", 5'd0, 24'h000099, 3'b001, 24'h000099, 3'b001);

    // Asynchronous reset in the middle of a valid output cycle.
    wr_auto_t(8'h41);
    wr_auto_t(8'h42);
    rd("pre_rst", 5'd0, 24'h424199, 3'b111, 24'h424199, 3'b111);
    #2 rst = 1'b1;
    #1;
    check("async_rd_valid", 32'(if_w.rd_valid), 32'(0));
    check("async_rd_data", 32'(if_w.rd_data), 32'(0));
    check("async_tap_vld", 32'(if_w.rd_tap_vld), 32'(0));
    check("async_wr_ptr", 32'(if_w.wr_ptr), 32'(0));
    check("async_wr_ptr_clamp", 32'(if_c.wr_ptr), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    rd("post_rst", 5'd0, 24'h000000, 3'b000, 24'h000000, 3'b000);

    repeat (3) @(negedge clk);
    check("wrap_queue_drained", 32'(q_w.size()), 32'(0));
    check("clamp_queue_drained", 32'(q_c.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
